// File: rtl/joybus_pkg.sv
// Shared definitions for the Joybus response serializer.
// Holds the FSM state type, the default level width, the counter widths and
// the 4-level wire encodings. Encodings are MSB-first: bit 3 is the first
// level of the symbol, and a 1 means "pull the line low".
package joybus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_STOP = 2'd2
    } state_t;

    localparam int unsigned LEVEL_WIDTH_DEF = 2;
    localparam int unsigned LVL_CNT_W       = 4;

    // Data bits: 0 = L,L,L,H ; 1 = L,H,H,H
    localparam logic [3:0] ENC_ZERO         = 4'b1110;
    localparam logic [3:0] ENC_ONE          = 4'b1000;
    // Stop bits use only the first three levels; the fourth is never sent.
    localparam logic [3:0] ENC_CTRL_STOP    = 4'b1100;
    localparam logic [3:0] ENC_CONSOLE_STOP = 4'b1000;

    localparam logic [1:0] STOP_LAST_IDX    = 2'd2;

    // Line drive for level idx (0 = first) of a 4-level pattern.
    function automatic logic level_is_low(input logic [3:0] pat, input logic [1:0] idx);
        return pat[~idx];
    endfunction

endpackage

// File: rtl/joybus_level_timer.sv
// Level and bit timing for the Joybus serializer.
// Counts sample_clk cycles within a level (wrapping at LEVEL_WIDTH-1), the
// level index within a symbol (0..3) and the bit index within a byte (7..0).
// Ports:
//   sample_clk, reset     clock and synchronous active-high reset
//   clear                 force counters to the start of a byte next cycle
//   enable                advance counters this cycle
//   level_idx             current level index within the symbol
//   level_end_c           last cycle of the current level
//   bit_end_c             last cycle of the current bit
//   byte_end_c            last cycle of bit 0
//   level_idx_nxt_c       level index the counters will hold next cycle
//   byte_end_nxt_c        next cycle will be the last cycle of bit 0
module joybus_level_timer
    import joybus_pkg::*;
#(
    parameter int unsigned LEVEL_WIDTH = LEVEL_WIDTH_DEF
) (
    input  logic       sample_clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       enable,
    output logic [1:0] level_idx,
    output logic       level_end_c,
    output logic       bit_end_c,
    output logic       byte_end_c,
    output logic [1:0] level_idx_nxt_c,
    output logic       byte_end_nxt_c
);

    localparam logic [LVL_CNT_W-1:0] LVL_LAST = LVL_CNT_W'(LEVEL_WIDTH - 1);

    logic [LVL_CNT_W-1:0] lvl_cnt;
    logic [LVL_CNT_W-1:0] lvl_cnt_nxt;
    logic [2:0]           bit_cnt;
    logic [2:0]           bit_cnt_nxt;

    // Strobes from the current counter values
    assign level_end_c = (lvl_cnt == LVL_LAST);
    assign bit_end_c   = level_end_c && (level_idx == 2'd3);
    assign byte_end_c  = bit_end_c && (bit_cnt == 3'd0);

    // Next counter values; level index and bit counter wrap naturally
    always_comb begin
        lvl_cnt_nxt     = lvl_cnt;
        level_idx_nxt_c = level_idx;
        bit_cnt_nxt     = bit_cnt;
        if (clear) begin
            lvl_cnt_nxt     = '0;
            level_idx_nxt_c = 2'd0;
            bit_cnt_nxt     = 3'd7;
        end else if (enable) begin
            lvl_cnt_nxt = level_end_c ? '0 : lvl_cnt + LVL_CNT_W'(1);
            if (level_end_c) begin
                level_idx_nxt_c = level_idx + 2'd1;
            end
            if (bit_end_c) begin
                bit_cnt_nxt = bit_cnt - 3'd1;
            end
        end
    end

    // Lets the parent register byte_ready one cycle ahead
    assign byte_end_nxt_c = (lvl_cnt_nxt == LVL_LAST) && (level_idx_nxt_c == 2'd3)
                            && (bit_cnt_nxt == 3'd0);

    // Counter registers
    always_ff @(posedge sample_clk) begin
        if (reset) begin
            lvl_cnt   <= '0;
            level_idx <= 2'd0;
            bit_cnt   <= 3'd7;
        end else begin
            lvl_cnt   <= lvl_cnt_nxt;
            level_idx <= level_idx_nxt_c;
            bit_cnt   <= bit_cnt_nxt;
        end
    end

endmodule

// File: rtl/joybus_tx_serializer.sv
// Joybus response serializer: sends a frame of bytes MSB first as 4-level
// symbols on an open-drain line, followed by a stop bit.
// Optional feature macro: JOYBUS_TX_CONSOLE_STOP_EN adds stop_sel to pick the
// console stop (L,H,H) instead of the controller stop (L,L,H) per frame.
// Ports:
//   sample_clk, reset     clock and synchronous active-high reset
//   stop_sel              (macro only) 1 = console stop, sampled on first byte
//   byte_data/valid/last  byte stream in; byte_last marks the frame's final byte
//   byte_ready            byte accepted this cycle when byte_valid is high
//   tx_low                1 = pull line low, 0 = release
//   busy                  frame in progress
//   done                  one-cycle pulse on the first idle cycle after a frame
//   underrun              one-cycle pulse when the next byte did not arrive
module joybus_tx_serializer
    import joybus_pkg::*;
#(
    parameter int unsigned LEVEL_WIDTH = LEVEL_WIDTH_DEF
) (
    input  logic       sample_clk,
    input  logic       reset,
`ifdef JOYBUS_TX_CONSOLE_STOP_EN
    input  logic       stop_sel,
`endif
    input  logic [7:0] byte_data,
    input  logic       byte_valid,
    input  logic       byte_last,
    output logic       byte_ready,
    output logic       tx_low,
    output logic       busy,
    output logic       done,
    output logic       underrun
);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] shreg;
    logic [7:0] shreg_nxt;
    logic       last_r;
    logic       last_nxt;
    logic [3:0] stop_pat;
    logic [3:0] stop_pat_nxt;
    logic       tx_low_nxt;
    logic       byte_ready_nxt;
    logic       done_nxt;
    logic       underrun_nxt;
    logic       handshake_c;
    logic       timer_clear_c;
    logic       timer_en_c;
    logic [1:0] level_idx;
    logic       level_end_c;
    logic       bit_end_c;
    logic       byte_end_c;
    logic [1:0] level_idx_nxt_c;
    logic       byte_end_nxt_c;

    assign handshake_c   = byte_valid && byte_ready;
    assign timer_clear_c = (state_nxt == ST_IDLE);
    assign timer_en_c    = (state != ST_IDLE);

    joybus_level_timer #(
        .LEVEL_WIDTH (LEVEL_WIDTH)
    ) u_timer (
        .sample_clk      (sample_clk),
        .reset           (reset),
        .clear           (timer_clear_c),
        .enable          (timer_en_c),
        .level_idx       (level_idx),
        .level_end_c     (level_end_c),
        .bit_end_c       (bit_end_c),
        .byte_end_c      (byte_end_c),
        .level_idx_nxt_c (level_idx_nxt_c),
        .byte_end_nxt_c  (byte_end_nxt_c)
    );

    // Next state, shift register and frame attributes
    always_comb begin
        state_nxt    = state;
        shreg_nxt    = shreg;
        last_nxt     = last_r;
        stop_pat_nxt = stop_pat;
        done_nxt     = 1'b0;
        underrun_nxt = 1'b0;
        case (state)
            ST_IDLE: begin
                if (handshake_c) begin
                    state_nxt = ST_SEND;
                    shreg_nxt = byte_data;
                    last_nxt  = byte_last;
`ifdef JOYBUS_TX_CONSOLE_STOP_EN
                    stop_pat_nxt = stop_sel ? ENC_CONSOLE_STOP : ENC_CTRL_STOP;
`else
                    stop_pat_nxt = ENC_CTRL_STOP;
`endif
                end
            end
            ST_SEND: begin
                if (byte_end_c) begin
                    // byte_ready is only high here for a non-final byte
                    if (!last_r && handshake_c) begin
                        shreg_nxt = byte_data;
                        last_nxt  = byte_last;
                    end else begin
                        state_nxt    = ST_STOP;
                        underrun_nxt = !last_r;
                    end
                end else if (bit_end_c) begin
                    shreg_nxt = {shreg[6:0], 1'b0};
                end
            end
            ST_STOP: begin
                if (level_end_c && (level_idx == STOP_LAST_IDX)) begin
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Line level for the next cycle
    always_comb begin
        tx_low_nxt = 1'b0;
        case (state_nxt)
            ST_SEND: tx_low_nxt = level_is_low(shreg_nxt[7] ? ENC_ONE : ENC_ZERO, level_idx_nxt_c);
            ST_STOP: tx_low_nxt = level_is_low(stop_pat_nxt, level_idx_nxt_c);
            default: tx_low_nxt = 1'b0;
        endcase
    end

    assign byte_ready_nxt = (state_nxt == ST_IDLE)
                            || ((state_nxt == ST_SEND) && byte_end_nxt_c && !last_nxt);

    // State and output registers
    always_ff @(posedge sample_clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            shreg      <= 8'd0;
            last_r     <= 1'b0;
            stop_pat   <= ENC_CTRL_STOP;
            tx_low     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            underrun   <= 1'b0;
            byte_ready <= 1'b1;
        end else begin
            state      <= state_nxt;
            shreg      <= shreg_nxt;
            last_r     <= last_nxt;
            stop_pat   <= stop_pat_nxt;
            tx_low     <= tx_low_nxt;
            busy       <= (state_nxt != ST_IDLE);
            done       <= done_nxt;
            underrun   <= underrun_nxt;
            byte_ready <= byte_ready_nxt;
        end
    end

endmodule

// File: tb/tb_joybus_tx_serializer.sv
// Scoreboard bench for joybus_tx_serializer. The driver pushes the expected
// per-cycle line waveform, byte_ready pattern, busy length and underrun
// outcome of each frame; a monitor pops and compares while the DUT is busy.
module tb_joybus_tx_serializer;

    localparam int unsigned LW = 2;

    logic       sample_clk = 1'b0;
    logic       reset;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       byte_last;
    logic       byte_ready;
    logic       tx_low;
    logic       busy;
    logic       done;
    logic       underrun;
`ifdef JOYBUS_TX_CONSOLE_STOP_EN
    logic       stop_sel;
`endif

    int tests = 0;
    int fails = 0;
    bit mon_off = 1'b1;

    logic [1:0] exp_q[$];   // {tx_low, byte_ready} per busy cycle
    int         len_q[$];
    int         ur_q[$];
    logic [7:0] fb[$];      // bytes of the frame being sent

    always #5 sample_clk = ~sample_clk;

    joybus_tx_serializer #(
        .LEVEL_WIDTH (LW)
    ) dut (
        .sample_clk (sample_clk),
        .reset      (reset),
`ifdef JOYBUS_TX_CONSOLE_STOP_EN
        .stop_sel   (stop_sel),
`endif
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_last  (byte_last),
        .byte_ready (byte_ready),
        .tx_low     (tx_low),
        .busy       (busy),
        .done       (done),
        .underrun   (underrun)
    );

    task automatic check(input string name, input logic act, input logic req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %b, required %b at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d at %0t", name, act, req, $time);
        end
    endtask

    // Expected waveform from the line protocol: each bit is 4 levels of LW
    // cycles, 0 = LLLH, 1 = LHHH; byte_ready only in the last cycle of a byte
    // that is not flagged last; then a 3-level stop.
    task automatic push_model(input bit flast, input bit console);
        int   n;
        bit   bv;
        bit   low;
        bit   rdy;
        n = fb.size();
        for (int i = 0; i < n; i++) begin
            for (int b = 7; b >= 0; b--) begin
                bv = fb[i][b];
                for (int lv = 0; lv < 4; lv++) begin
                    low = (lv == 0) || (!bv && lv < 3);
                    for (int c = 0; c < int'(LW); c++) begin
                        rdy = (b == 0) && (lv == 3) && (c == int'(LW) - 1)
                              && !((i == n - 1) && flast);
                        exp_q.push_back({low, rdy});
                    end
                end
            end
        end
        for (int lv = 0; lv < 3; lv++) begin
            low = (lv == 0) || (!console && lv == 1);
            for (int c = 0; c < int'(LW); c++) exp_q.push_back({low, 1'b0});
        end
        len_q.push_back(n * 32 * int'(LW) + 3 * int'(LW));
        ur_q.push_back(flast ? 0 : 1);
    endtask

    task automatic wait_idle();
        int budget;
        budget = 0;
        while (busy && budget < 5000) begin
            @(negedge sample_clk);
            budget++;
        end
        if (busy) begin
            tests++;
            fails++;
            $display("FAIL wait_idle: busy still 1 after %0d cycles", budget);
        end
        @(posedge sample_clk);
        #1;
    endtask

    // Drives fb as one frame; each next byte is held valid as soon as the
    // previous one is taken, so acceptance timing is left to the DUT.
    task automatic send_frame(input bit flast, input bit console);
        int n;
        bit hs;
        int budget;
        n = fb.size();
        push_model(flast, console);
`ifdef JOYBUS_TX_CONSOLE_STOP_EN
        stop_sel = console;
`endif
        for (int i = 0; i < n; i++) begin
            byte_data  = fb[i];
            byte_last  = (i == n - 1) ? flast : 1'b0;
            byte_valid = 1'b1;
            hs         = 1'b0;
            budget     = 0;
            while (!hs && budget < 3000) begin
                @(negedge sample_clk);
                hs = byte_ready;
                @(posedge sample_clk);
                budget++;
            end
            #1;
            if (!hs) begin
                tests++;
                fails++;
                $display("FAIL handshake: byte %0d not accepted after %0d cycles", i, budget);
            end
`ifdef JOYBUS_TX_CONSOLE_STOP_EN
            stop_sel = ~console;
`endif
        end
        byte_valid = 1'b0;
        byte_last  = 1'b0;
        byte_data  = 8'($urandom);
        wait_idle();
    endtask

    task automatic monitor();
        bit         in_frame;
        int         run;
        int         urc;
        logic [1:0] e;
        in_frame = 1'b0;
        run      = 0;
        urc      = 0;
        forever begin
            @(negedge sample_clk);
            if (mon_off) begin
                in_frame = 1'b0;
            end else if (busy) begin
                if (!in_frame) begin
                    in_frame = 1'b1;
                    run      = 0;
                    urc      = 0;
                end
                run++;
                if (underrun) urc++;
                check("done_in_frame", done, 1'b0);
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL busy_extra: busy=1 with no expected cycle at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("tx_low", tx_low, e[1]);
                    check("byte_ready", byte_ready, e[0]);
                end
            end else begin
                check("idle_tx_low", tx_low, 1'b0);
                check("idle_byte_ready", byte_ready, 1'b1);
                check("idle_underrun", underrun, 1'b0);
                if (in_frame) begin
                    in_frame = 1'b0;
                    check("done_pulse", done, 1'b1);
                    if (len_q.size() != 0) check_int("busy_len", run, len_q.pop_front());
                    if (ur_q.size() != 0) check_int("underrun_pulses", urc, ur_q.pop_front());
                end else begin
                    check("done_idle", done, 1'b0);
                end
            end
        end
    endtask

    task automatic set_frame3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input int n);
        fb.delete();
        fb.push_back(a);
        if (n > 1) fb.push_back(b);
        if (n > 2) fb.push_back(c);
    endtask

    initial begin
        int n;
        bit fl;
        bit con;
        reset      = 1'b1;
        byte_valid = 1'b0;
        byte_last  = 1'b0;
        byte_data  = 8'd0;
`ifdef JOYBUS_TX_CONSOLE_STOP_EN
        stop_sel   = 1'b0;
`endif
        fork
            monitor();
            begin
                #500000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1, "watchdog timeout");
            end
        join_none

        // Reset state
        repeat (3) @(posedge sample_clk);
        #1 reset = 1'b0;
        @(negedge sample_clk);
        check("rst_tx_low", tx_low, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_byte_ready", byte_ready, 1'b1);
        check("rst_done", done, 1'b0);
        check("rst_underrun", underrun, 1'b0);
        mon_off = 1'b0;
        @(posedge sample_clk);
        #1;

        // Three-byte frame, single byte, back-to-back, underrun
        set_frame3(8'h05, 8'h00, 8'h00, 3);
        send_frame(1'b1, 1'b0);
        set_frame3(8'h80, 8'h00, 8'h00, 1);
        send_frame(1'b1, 1'b0);
        set_frame3(8'hFF, 8'h00, 8'h00, 2);
        send_frame(1'b1, 1'b0);
        set_frame3(8'hA5, 8'h00, 8'h00, 1);
        send_frame(1'b0, 1'b0);

        // Reset in cycle 20 of a frame
        mon_off = 1'b1;
        @(negedge sample_clk);
        @(posedge sample_clk);
        #1;
        byte_data  = 8'h5A;
        byte_last  = 1'b1;
        byte_valid = 1'b1;
        @(posedge sample_clk);
        #1 byte_valid = 1'b0;
        repeat (19) @(posedge sample_clk);
        #1 reset = 1'b1;
        @(posedge sample_clk);
        #1 reset = 1'b0;
        @(negedge sample_clk);
        check("midrst_tx_low", tx_low, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_byte_ready", byte_ready, 1'b1);
        check("midrst_done", done, 1'b0);
        check("midrst_underrun", underrun, 1'b0);

        // Reset wins over a same-cycle handshake
        @(posedge sample_clk);
        #1;
        reset      = 1'b1;
        byte_valid = 1'b1;
        byte_data  = 8'hC3;
        byte_last  = 1'b1;
        @(posedge sample_clk);
        #1;
        reset      = 1'b0;
        byte_valid = 1'b0;
        @(negedge sample_clk);
        check("rst_hs_busy", busy, 1'b0);
        @(negedge sample_clk);
        check("rst_hs_busy2", busy, 1'b0);
        check("rst_hs_tx_low", tx_low, 1'b0);
        mon_off = 1'b0;
        @(posedge sample_clk);
        #1;

        set_frame3(8'h3C, 8'h00, 8'h00, 1);
        send_frame(1'b1, 1'b0);

`ifdef JOYBUS_TX_CONSOLE_STOP_EN
        set_frame3(8'h00, 8'h00, 8'h00, 1);
        send_frame(1'b1, 1'b1);
`endif

        // Randomized frames
        for (int f = 0; f < 25; f++) begin
            n = int'($urandom_range(1, 3));
            set_frame3(8'($urandom), 8'($urandom), 8'($urandom), n);
            fl = ($urandom_range(0, 3) != 0);
`ifdef JOYBUS_TX_CONSOLE_STOP_EN
            con = 1'($urandom);
`else
            con = 1'b0;
`endif
            send_frame(fl, con);
            repeat ($urandom_range(0, 3)) @(posedge sample_clk);
            #1;
        end

        repeat (5) @(negedge sample_clk);
        check_int("exp_q_drained", exp_q.size(), 0);
        check_int("len_q_drained", len_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
